// File: rtl/input_flow_handler_mc.sv
// input_flow_handler_mc: per-lane two-phase diff-pair token decode, buffering, release and skew check; zero-latency bypass under INPUT_FLOW_BYPASS_EN
module input_flow_handler_mc #(
  parameter int CHANNELS = 4,
  parameter int DEPTH = 4,
  parameter int SKEW_MAX = 3,
  localparam int CW = $clog2(DEPTH+1)
) (
  input  logic                   clka,
  input  logic                   rsta,
  input  logic [CHANNELS-1:0]    diff_pair_p,
  input  logic [CHANNELS-1:0]    diff_pair_n,
  input  logic [CHANNELS-1:0]    pipe_stall,
  input  logic                   err_clear,
  output logic [CHANNELS-1:0]    pipe_en,
  output logic [CHANNELS-1:0]    lane_full,
  output logic [CHANNELS-1:0]    skew_error,
  output logic [CHANNELS*CW-1:0] pending
);
  localparam int SW = $clog2(SKEW_MAX+1);
  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    logic          r_p, r_n, r_err;
    logic [CW-1:0] r_cnt;
    logic [SW-1:0] r_skew;
    logic          w_tp, w_tn, w_token, w_half, w_accept, w_rel, w_byp;
    // Phase decode against expected levels; accept/release use registered count only
    always_comb begin
      w_tp = diff_pair_p[i] ^ r_p;
      w_tn = diff_pair_n[i] ^ r_n;
      w_token = w_tp & w_tn;
      w_half = w_tp ^ w_tn;
      w_accept = w_token & (r_cnt < CW'(DEPTH));
      w_rel = (r_cnt != '0) & ~pipe_stall[i];
`ifdef INPUT_FLOW_BYPASS_EN
      w_byp = w_token & (r_cnt == '0) & ~pipe_stall[i];
`else
      w_byp = 1'b0;
`endif
    end
    assign pipe_en[i] = w_rel | w_byp;
    assign lane_full[i] = r_cnt == CW'(DEPTH);
    assign skew_error[i] = r_err;
    assign pending[i*CW +: CW] = r_cnt;
    // Expected levels flip on accept; bypassed tokens skip the counter; skew counter saturates while HALF
    always_ff @(posedge clka or negedge rsta) begin
      if (!rsta) begin
        r_p <= 1'b1;
        r_n <= 1'b0;
        r_cnt <= '0;
        r_skew <= '0;
        r_err <= 1'b0;
      end else begin
        if (w_accept) begin
          r_p <= ~r_p;
          r_n <= ~r_n;
        end
        r_cnt <= r_cnt + CW'(w_accept & ~w_byp) - CW'(w_rel);
        r_skew <= (err_clear | ~w_half) ? '0 : (r_skew == SW'(SKEW_MAX)) ? r_skew : r_skew + 1'b1;
        r_err <= err_clear ? 1'b0 : r_err | (w_half & (r_skew == SW'(SKEW_MAX)));
      end
    end
  end
endmodule
